// File: rtl/data_mem_controller.sv
// Processor-side data memory controller: decodes byte addresses onto a word RAM,
// handles sub-word loads with extension and sub-word stores via read-modify-write.
//
// state | meaning
// IDLE  | ready for a request; RAM address parked at 0
// LOAD  | reading the addressed word, extracting and extending the lane
// MERGE | reading the addressed word, splicing in the store lane
// WRITE | driving the store word into RAM
// RESP  | one-cycle completion pulse
module data_mem_controller #(
  parameter int          DATA_WIDTH = 32,
  parameter int          ADDR_WIDTH = 32,
  parameter int          DEPTH      = 50,
  parameter logic [31:0] BASE_ADDR  = 32'h1001_0000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_signed,
  input  logic [31:0]           req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  rsp_valid,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_err,
  output logic [DATA_WIDTH-1:0] ram_data,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  ram_we,
  input  logic [DATA_WIDTH-1:0] ram_q
);

  typedef enum logic [2:0] {IDLE, LOAD, MERGE, WRITE, RESP} state_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_BAD  = 2'b11;

  state_t                r_state;
  state_t                w_state_next;
  logic                  r_we;
  logic [1:0]            r_size;
  logic                  r_signed;
  logic [1:0]            r_off;
  logic [31:0]           r_wdata;
  logic [ADDR_WIDTH-1:0] r_idx;
  logic [31:0]           r_rdata;
  logic                  r_err;

  logic [31:0] w_offset;
  logic [31:0] w_index;
  logic        w_misalign;
  logic        w_err;
  logic [31:0] w_q32;
  logic [4:0]  w_shift;
  logic [31:0] w_shifted;
  logic [31:0] w_load;
  logic [31:0] w_mask;
  logic [31:0] w_merged;

  assign w_offset = req_addr - BASE_ADDR;
  assign w_index  = w_offset >> 2;

  always_comb begin
    w_misalign = 1'b0;
    case (req_size)
      SZ_HALF: w_misalign = req_addr[0];
      SZ_WORD: w_misalign = (req_addr[1:0] != 2'b00);
      SZ_BAD:  w_misalign = 1'b1;
      default: w_misalign = 1'b0;
    endcase
  end

  // Below-base check is needed separately: the subtraction wraps to a huge index.
  assign w_err = w_misalign || (req_addr < BASE_ADDR) || (w_index >= 32'(DEPTH));

  assign w_q32     = 32'(ram_q);
  assign w_shift   = {r_off, 3'b000};
  assign w_shifted = w_q32 >> w_shift;

  always_comb begin
    w_load = w_q32;
    case (r_size)
      SZ_BYTE: w_load = {{24{r_signed & w_shifted[7]}}, w_shifted[7:0]};
      SZ_HALF: w_load = {{16{r_signed & w_shifted[15]}}, w_shifted[15:0]};
      default: w_load = w_q32;
    endcase
  end

  assign w_mask   = ((r_size == SZ_BYTE) ? 32'h0000_00FF : 32'h0000_FFFF) << w_shift;
  assign w_merged = (w_q32 & ~w_mask) | ((r_wdata << w_shift) & w_mask);

  always_comb begin
    w_state_next = r_state;
    req_ready    = 1'b0;
    rsp_valid    = 1'b0;
    ram_addr     = r_idx;
    ram_data     = DATA_WIDTH'(r_wdata);
    ram_we       = 1'b0;
    case (r_state)
      IDLE: begin
        req_ready = 1'b1;
        ram_addr  = '0;
        if (req_valid) begin
          if (w_err)                  w_state_next = RESP;
          else if (!req_we)           w_state_next = LOAD;
          else if (req_size == SZ_WORD) w_state_next = WRITE;
          else                        w_state_next = MERGE;
        end
      end
      LOAD:  w_state_next = RESP;
      MERGE: w_state_next = WRITE;
      WRITE: begin
        // Gated by reset so a reset landing here aborts the store.
        ram_we       = !reset;
        w_state_next = RESP;
      end
      RESP: begin
        rsp_valid    = 1'b1;
        w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_we     <= 1'b0;
      r_size   <= SZ_BYTE;
      r_signed <= 1'b0;
      r_off    <= 2'b00;
      r_wdata  <= '0;
      r_idx    <= '0;
      r_rdata  <= '0;
      r_err    <= 1'b0;
    end else begin
      r_state <= w_state_next;
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_we     <= req_we;
            r_size   <= req_size;
            r_signed <= req_signed;
            r_off    <= req_addr[1:0];
            r_wdata  <= req_wdata;
            r_idx    <= ADDR_WIDTH'(w_index);
            r_rdata  <= '0;
            r_err    <= w_err;
          end
        end
        LOAD:  r_rdata <= w_load;
        MERGE: r_wdata <= w_merged;
        RESP: begin
          r_rdata <= '0;
          r_err   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign rsp_rdata = r_rdata;
  assign rsp_err   = r_err;

endmodule

// File: tb/tb_data_mem_controller.sv
// Bench for data_mem_controller: harness RAM, arithmetic reference model of the
// memory contents and responses, directed scenarios followed by random traffic.
module tb_data_mem_controller;

  localparam int          DW    = 32;
  localparam int          AW    = 32;
  localparam int          DEPTH = 50;
  localparam logic [31:0] BASE  = 32'h1001_0000;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [1:0]    req_size;
  logic          req_signed;
  logic [31:0]   req_addr;
  logic [31:0]   req_wdata;
  logic          rsp_valid;
  logic [31:0]   rsp_rdata;
  logic          rsp_err;
  logic [DW-1:0] ram_data;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [DW-1:0] ram_q;

  int checks   = 0;
  int failures = 0;
  int we_count = 0;

  logic [31:0] mem     [DEPTH];
  logic [31:0] ref_mem [DEPTH];
  logic        tb_clr;

  always #5 clk = ~clk;

  data_mem_controller #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .BASE_ADDR(BASE)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .ram_data(ram_data), .ram_addr(ram_addr), .ram_we(ram_we), .ram_q(ram_q)
  );

  // Single-port RAM: asynchronous read, posedge write.
  assign ram_q = (ram_addr < DEPTH) ? mem[ram_addr[5:0]] : '0;

  always @(posedge clk) begin
    if (tb_clr) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (ram_we && ram_addr < DEPTH) begin
      mem[ram_addr[5:0]] <= ram_data;
    end
    if (ram_we) we_count <= we_count + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Reference model: decides the outcome from the access rules and updates ref_mem.
  task automatic model(input bit we, input logic [1:0] size, input bit sgn,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       output bit err, output int lat, output logic [31:0] rdata);
    longint idx;
    int     off;
    logic [31:0] w, v, mask;
    off   = int'(addr[1:0]);
    idx   = (longint'(addr) - longint'(BASE)) / 4;
    err   = (size == 2'd3) || (size == 2'd1 && (off % 2) != 0) ||
            (size == 2'd2 && off != 0) || (addr < BASE) || (idx >= DEPTH);
    rdata = 32'h0;
    if (err) begin
      lat = 1;
    end else if (!we) begin
      lat = 2;
      w   = ref_mem[idx];
      if (size == 2'd0) begin
        v = (w >> (8 * off)) & 32'hFF;
        if (sgn && v >= 32'h80) v = v + 32'hFFFF_FF00;
      end else if (size == 2'd1) begin
        v = (w >> (8 * off)) & 32'hFFFF;
        if (sgn && v >= 32'h8000) v = v + 32'hFFFF_0000;
      end else begin
        v = w;
      end
      rdata = v;
    end else if (size == 2'd2) begin
      lat          = 2;
      ref_mem[idx] = wdata;
    end else begin
      lat          = 3;
      mask         = ((size == 2'd0) ? 32'hFF : 32'hFFFF) << (8 * off);
      ref_mem[idx] = (ref_mem[idx] & ~mask) | ((wdata << (8 * off)) & mask);
    end
  endtask

  task automatic do_req(input string tag, input bit we, input logic [1:0] size, input bit sgn,
                        input logic [31:0] addr, input logic [31:0] wdata);
    bit          e;
    int          lat, cyc, we0;
    logic [31:0] rd;
    model(we, size, sgn, addr, wdata, e, lat, rd);
    @(negedge clk);
    check({tag, "/ready"}, {31'b0, req_ready}, 32'd1);
    req_valid  = 1'b1;
    req_we     = we;
    req_size   = size;
    req_signed = sgn;
    req_addr   = addr;
    req_wdata  = wdata;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    we0       = we_count;
    cyc       = 0;
    while (cyc < 8) begin
      @(negedge clk);
      cyc++;
      if (rsp_valid) break;
    end
    check({tag, "/lat"}, 32'(cyc), 32'(lat));
    check({tag, "/err"}, {31'b0, rsp_err}, {31'b0, e});
    check({tag, "/rdata"}, rsp_rdata, rd);
    if (e) check({tag, "/no_we"}, 32'(we_count), 32'(we0));
    @(negedge clk);
    check({tag, "/pulse"}, {31'b0, rsp_valid}, 32'd0);
  endtask

  initial begin
    bit          e;
    int          lat, cyc;
    logic [31:0] rd_a, rd_b, a;

    reset = 1'b1; tb_clr = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_signed = 1'b0;
    req_addr = '0; req_wdata = '0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    tb_clr = 1'b0;
    check("rst/ready", {31'b0, req_ready}, 32'd1);
    check("rst/rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("rst/rdata", rsp_rdata, 32'd0);
    check("rst/err", {31'b0, rsp_err}, 32'd0);
    check("rst/ram_we", {31'b0, ram_we}, 32'd0);
    check("rst/ram_addr", ram_addr, 32'd0);
    reset = 1'b0;

    // Word store then load
    do_req("st_w2", 1, 2'd2, 0, BASE + 32'h8, 32'hDEAD_BEEF);
    check("st_w2/mem", mem[2], 32'hDEAD_BEEF);
    do_req("ld_w2", 0, 2'd2, 0, BASE + 32'h8, 32'h0);

    // Sub-word store merge
    do_req("st_w0", 1, 2'd2, 0, BASE, 32'h1122_3344);
    do_req("st_b1", 1, 2'd0, 0, BASE + 32'h1, 32'h0000_00AA);
    check("st_b1/mem", mem[0], 32'h1122_AA44);
    do_req("st_h2", 1, 2'd1, 0, BASE + 32'h2, 32'h0000_BEEF);
    check("st_h2/mem", mem[0], 32'hBEEF_AA44);

    // Sign extension
    do_req("st_80f0", 1, 2'd2, 0, BASE, 32'h0000_80F0);
    do_req("ld_sb", 0, 2'd0, 1, BASE, 32'h0);
    do_req("ld_ub", 0, 2'd0, 0, BASE, 32'h0);
    do_req("ld_sh", 0, 2'd1, 1, BASE, 32'h0);
    do_req("ld_uh", 0, 2'd1, 0, BASE, 32'h0);

    // Faults
    do_req("e_misw", 0, 2'd2, 0, BASE + 32'h2, 32'h0);
    do_req("e_low", 0, 2'd2, 0, 32'h1000_FFFC, 32'h0);
    do_req("e_high", 0, 2'd2, 0, BASE + 32'(4 * DEPTH), 32'h0);
    do_req("e_size", 1, 2'd3, 0, BASE + 32'h4, 32'h5555_5555);
    do_req("e_mish", 1, 2'd1, 0, BASE + 32'h5, 32'h1234);
    do_req("last_ok", 1, 2'd2, 0, BASE + 32'(4 * (DEPTH - 1)), 32'hCAFE_F00D);

    // Busy: req_valid stays high across two requests
    model(0, 2'd2, 0, BASE + 32'h8, 32'h0, e, lat, rd_a);
    model(0, 2'd0, 0, BASE + 32'h9, 32'h0, e, lat, rd_b);
    @(negedge clk);
    check("busy/ready_a", {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_signed = 1'b0;
    req_addr = BASE + 32'h8; req_wdata = '0;
    @(posedge clk);
    #1;
    req_size = 2'd0; req_addr = BASE + 32'h9;
    cyc = 0;
    while (cyc < 8) begin
      @(negedge clk);
      cyc++;
      if (rsp_valid) break;
      check("busy/ready_low", {31'b0, req_ready}, 32'd0);
    end
    check("busy/lat_a", 32'(cyc), 32'd2);
    check("busy/rdata_a", rsp_rdata, rd_a);
    @(negedge clk);
    check("busy/ready_b", {31'b0, req_ready}, 32'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    cyc = 0;
    while (cyc < 8) begin
      @(negedge clk);
      cyc++;
      if (rsp_valid) break;
    end
    check("busy/lat_b", 32'(cyc), 32'd2);
    check("busy/rdata_b", rsp_rdata, rd_b);

    // Reset during WRITE aborts the store
    @(negedge clk);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_signed = 1'b0;
    req_addr = BASE + 32'hC; req_wdata = 32'h1234_5678;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    check("rstw/in_write", {31'b0, ram_we}, 32'd1);
    reset = 1'b1;
    #1;
    check("rstw/we_gated", {31'b0, ram_we}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    check("rstw/ready", {31'b0, req_ready}, 32'd1);
    check("rstw/mem3", mem[3], 32'h0);
    for (int i = 0; i < 3; i++) begin
      check("rstw/no_rsp", {31'b0, rsp_valid}, 32'd0);
      @(negedge clk);
    end

    // Random traffic
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 7) == 0)
        a = BASE - 32'(4 * $urandom_range(1, 4)) + 32'($urandom_range(0, 3));
      else
        a = BASE + 32'(4 * $urandom_range(0, DEPTH + 1)) + 32'($urandom_range(0, 3));
      do_req($sformatf("rnd%0d", n), bit'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
             bit'($urandom_range(0, 1)), a, $urandom);
    end

    for (int i = 0; i < DEPTH; i++) check($sformatf("final/mem%0d", i), mem[i], ref_mem[i]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/data_mem_controller.md
DATA_MEM_CONTROLLER -- requirements
Module: data_mem_controller

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, data word width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, width of RAM word-index port.
REQ-003 SHALL have parameter DEPTH, default 50, number of RAM words behind the controller.
REQ-004 SHALL have parameter BASE_ADDR, default 32'h1001_0000, byte address mapped to RAM word 0.
REQ-005 SHALL have port clk  input  1  single clock; all state changes on posedge clk.
REQ-006 SHALL have port reset  input  1  reset, synchronous and active-high.
REQ-007 SHALL have port req_valid  input  1  processor access request.
REQ-008 SHALL have port req_ready  output  1  controller can accept a request this cycle.
REQ-009 SHALL have port req_we  input  1  1 = store, 0 = load.
REQ-010 SHALL have port req_size  input  2  00 byte, 01 halfword, 10 word, 11 illegal.
REQ-011 SHALL have port req_signed  input  1  sign-extend sub-word loads when 1, zero-extend when 0.
REQ-012 SHALL have port req_addr  input  32  byte address.
REQ-013 SHALL have port req_wdata  input  32  store data, right-aligned for sub-word stores.
REQ-014 SHALL have port rsp_valid  output  1  one-cycle completion pulse.
REQ-015 SHALL have port rsp_rdata  output  32  load result, valid with rsp_valid; 0 for stores and errors.
REQ-016 SHALL have port rsp_err  output  1  access faulted, valid with rsp_valid.
REQ-017 SHALL have ports ram_data (output, DATA_WIDTH), ram_addr (output, ADDR_WIDTH), ram_we (output, 1), ram_q (input, DATA_WIDTH) connecting to a single-port RAM with asynchronous read and posedge-clk write.

Function
REQ-018 SHALL implement FSM states IDLE, LOAD, MERGE, WRITE, RESP; req_ready = 1 only in IDLE.
REQ-019 SHALL accept a request in IDLE when req_valid = 1, registering we, size, signed, byte offset addr[1:0], wdata, and word index = (req_addr - BASE_ADDR) >> 2.
REQ-020 SHALL flag error when: req_size = 11; halfword with addr[0] = 1; word with addr[1:0] != 0; req_addr < BASE_ADDR; or word index >= DEPTH.
REQ-021 SHALL transition on accept: error -> RESP; load -> LOAD; word store -> WRITE; byte/halfword store -> MERGE.
REQ-022 SHALL in LOAD capture ram_q, extract the addressed lane (little-endian: offset 0 = bits[7:0], halfword offset 2 = bits[31:16]), extend per req_signed, then go to RESP.
REQ-023 SHALL in MERGE capture ram_q, replace only the addressed byte/halfword lane with the low bits of wdata, then go to WRITE.
REQ-024 SHALL in WRITE drive ram_we = 1, ram_data = wdata (word) or merged word (sub-word), then go to RESP.
REQ-025 SHALL in RESP assert rsp_valid for exactly one cycle, then return to IDLE.
REQ-026 SHALL drive ram_addr = registered index in LOAD/MERGE/WRITE/RESP and 0 in IDLE; ram_we = 0 outside WRITE.
REQ-027 SHALL never assert ram_we for an erroring request.
REQ-028 SHALL meet latency (accept cycle T): error rsp at T+1; load and word store rsp at T+2; sub-word store rsp at T+3.
REQ-029 SHALL ignore req_valid in every state other than IDLE; back-to-back requests are accepted the cycle after RESP.

Reset
REQ-030 SHALL on reset = 1 at a posedge enter IDLE and clear all registered outputs: req_ready = 1 after reset, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0.
REQ-031 SHALL gate ram_we = (state == WRITE) && !reset so reset asserted during WRITE aborts the store with no RAM update.
REQ-032 SHALL discard any in-flight request on reset, producing no rsp_valid for it.

Verification
REQ-033 SHALL cover word store then load: store 0xDEADBEEF @0x10010008, then load word @0x10010008 -> RAM word 2 = 0xDEADBEEF, rsp at T+2 each, rsp_rdata = 0xDEADBEEF.
REQ-034 SHALL cover sub-word store merge: word 0 = 0x11223344, store byte 0xAA @0x10010001 -> word 0 = 0x1122AA44, rsp at T+3; store half 0xBEEF @0x10010002 -> 0xBEEFAA44.
REQ-035 SHALL cover sign extension: word 0 = 0x000080F0, signed byte load @0x10010000 -> 0xFFFFFFF0; unsigned -> 0x000000F0; signed half -> 0xFFFF80F0.
REQ-036 SHALL cover errors: word load @0x10010002, load @0x1000FFFC, load @BASE_ADDR + 4*DEPTH, and req_size = 11 -> each rsp_err = 1 at T+1, ram_we never asserted.
REQ-037 SHALL cover reset in WRITE: assert reset during the WRITE cycle of a store of 0x12345678 to word 3 (previously 0) -> word 3 remains 0, no rsp_valid, req_ready = 1 next cycle.
REQ-038 SHALL cover busy behaviour: req_valid held high continuously with two requests -> second accepted only the cycle after the first rsp_valid.
